reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the core's 2-read/1-write integer register file.
- Generalises data width and register count.
- Adds three behaviours:
  - x0 hard-wired to zero.
  - A post-reset clear sequencer that zeroes the array one entry per cycle and reports completion.
  - A per-register pending-write scoreboard, so multi-cycle producers (loads, future mul/div) can stall dependent reads.
- Sits between decode (read addresses, issue) and writeback (write port).

Parameters:
- XLEN, 32, data width of each register and of all data ports.
- ADDR_W, 5, register address width; register count NREGS = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never marked pending; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a1  in  ADDR_W  read address, port 1.
- a2  in  ADDR_W  read address, port 2.
- rd1  out  XLEN  read data, port 1 (combinational).
- rd2  out  XLEN  read data, port 2 (combinational).
- a3  in  ADDR_W  write address.
- wd3  in  XLEN  write data.
- we3  in  1  write enable; also clears the scoreboard bit of a3.
- sb_set  in  1  issue of a multi-cycle producer; marks sb_addr pending.
- sb_addr  in  ADDR_W  destination register being issued.
- busy1  out  1  register a1 has a pending write.
- busy2  out  1  register a2 has a pending write.
- init_done  out  1  clear sequence complete; array valid.

Behaviour:
- Reset (rst=1, asynchronous):
  - init_done=0.
  - All scoreboard bits cleared; busy1=busy2=0.
  - Clear counter reset to 0.
  - rd1=rd2=0 while rst=1.
  - Array contents are not reset directly.
- FSM states:
  - CLEAR: entered on reset release. Each cycle writes 0 to array[cnt] and increments cnt. After entry NREGS-1 is written, go to READY next cycle. Takes exactly NREGS cycles. init_done=0 throughout.
  - READY: init_done=1. Stays in READY until rst.
- Reset asserted mid-CLEAR aborts the sequence; it restarts at index 0 after release.
- While init_done=0:
  - we3 and sb_set are ignored.
  - rd1, rd2, busy1, busy2 read 0.
- Read path (READY): rdN = array[aN] combinationally, except rdN = 0 when ZERO_REG=1 and aN=0.
- Write: at posedge, if we3 and READY (and not (ZERO_REG and a3=0)), array[a3] <= wd3. New value visible to reads from the next cycle unless the optional feature is compiled in.
- Scoreboard (READY only):
  - sb_set sets pend[sb_addr] at posedge.
  - we3 clears pend[a3] at posedge.
  - Both in the same cycle on the same address: set wins (newer producer owns the register).
  - Both on different addresses: both take effect.
  - ZERO_REG=1: pend[0] is always 0.
- busyN = pend[aN], combinational from the current scoreboard (registered) state. Same-cycle set/clear affects busy the following cycle.
- Read and write of the same register in one cycle (no bypass): read returns the old value.
- Widths: no arithmetic on data. Clear counter is ADDR_W+1 bits so the end condition is reachable without wrap.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: in READY, if we3 and a3 = aN (and not (ZERO_REG and aN=0)), rdN = wd3 in the same cycle.
  - busyN is additionally forced 0 when that forwarding condition holds, since the pending value is arriving now.
- Undefined: no forwarding; reads return the array value and busyN is the plain scoreboard bit.

Test Plan:
- Reset then release, NREGS=32 → init_done low for exactly 32 cycles, high on cycle 33; reading any address afterwards gives 0x00000000.
- Pulse rst at clear cycle 10 → init_done stays 0 and rises exactly 32 cycles after the second release; a we3 issued during CLEAR to x5 with 0xDEADBEEF leaves x5=0.
- READY: write x7=0x12345678, next cycle a1=7 → rd1=0x12345678. Write x0=0xFFFFFFFF then a2=0 → rd2=0. sb_set on x0 → busy never asserts.
- Same-cycle we3 a3=9 wd3=0xA5A5A5A5 with a1=9:
  - without REGFILE_BYPASS_EN → rd1 = old value 0;
  - with REGFILE_BYPASS_EN → rd1 = 0xA5A5A5A5 in that cycle.
- sb_set x12 → next cycle a1=12 gives busy1=1. Then we3 to x12 together with sb_set x12 in the same cycle → busy1 remains 1. Later we3 alone to x12 → busy1=0 the next cycle.
- sb_set x3 and we3 x4 in the same cycle, with pend[4] set beforehand → next cycle busy(3)=1, busy(4)=0.

Source files
------------

// File: rtl/reg_file_sb.sv
// 2R/1W register file with x0 zeroing, a post-reset clear sequencer and a pending-write scoreboard.
// Reads and busy are combinational and writes land next cycle; define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_sb #(
   parameter int XLEN     = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] a1,
   input  logic [ADDR_W-1:0] a2,
   output logic [XLEN-1:0]   rd1,
   output logic [XLEN-1:0]   rd2,
   input  logic [ADDR_W-1:0] a3,
   input  logic [XLEN-1:0]   wd3,
   input  logic              we3,
   input  logic              sb_set,
   input  logic [ADDR_W-1:0] sb_addr,
   output logic              busy1,
   output logic              busy2,
   output logic              init_done
);
   localparam int NREGS = 2**ADDR_W;
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NREGS - 1);
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   logic [0:0]       state;
   logic [ADDR_W:0]  cnt;
   logic [XLEN-1:0]  mem [NREGS];
   logic [NREGS-1:0] pend;
   logic [NREGS-1:0] pend_nxt;
   logic             ready;
   logic             wr_ok;
   logic             zero1;
   logic             zero2;
   logic             fwd1;
   logic             fwd2;

   assign ready     = (state == ST_READY);
   assign init_done = ready;
   assign wr_ok     = ready && we3 && !((ZERO_REG != 0) && (a3 == '0));
   assign zero1     = (ZERO_REG != 0) && (a1 == '0);
   assign zero2     = (ZERO_REG != 0) && (a2 == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_CLEAR;
         cnt   <= '0;
         pend  <= '0;
      end else begin
         pend <= pend_nxt;
         if (state == ST_CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX)
               state <= ST_READY;
         end
      end
   end

   // Array has no reset of its own; the sequencer zeroes one entry per cycle after release.
   always_ff @(posedge clk) begin
      if (!rst && (state == ST_CLEAR))
         mem[cnt[ADDR_W-1:0]] <= '0;
      else if (wr_ok)
         mem[a3] <= wd3;
   end

   // Set is applied after clear so a new producer keeps ownership on an address collision.
   always_comb begin
      pend_nxt = pend;
      if (ready) begin
         if (we3)
            pend_nxt[a3] = 1'b0;
         if (sb_set)
            pend_nxt[sb_addr] = 1'b1;
      end
      if (ZERO_REG != 0)
         pend_nxt[0] = 1'b0;
   end

`ifdef REGFILE_BYPASS_EN
   assign fwd1 = wr_ok && (a3 == a1);
   assign fwd2 = wr_ok && (a3 == a2);
`else
   assign fwd1 = 1'b0;
   assign fwd2 = 1'b0;
`endif

   assign rd1   = (!ready || zero1) ? '0 : (fwd1 ? wd3 : mem[a1]);
   assign rd2   = (!ready || zero2) ? '0 : (fwd2 ? wd3 : mem[a2]);
   assign busy1 = ready && pend[a1] && !fwd1;
   assign busy2 = ready && pend[a2] && !fwd2;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and randomized bench for reg_file_sb against an array/flag reference model.
module tb_reg_file_sb;
   localparam int XLEN   = 32;
   localparam int ADDR_W = 5;
   localparam int NREGS  = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] a1 = '0, a2 = '0, a3 = '0, sb_addr = '0;
   logic [XLEN-1:0]   wd3 = '0;
   logic              we3 = 1'b0, sb_set = 1'b0;
   logic [XLEN-1:0]   rd1, rd2;
   logic              busy1, busy2, init_done;

   int total = 0;
   int bad   = 0;

   logic [XLEN-1:0] mem_m [NREGS];
   bit              pend_m [NREGS];
   bit              ready_m;
   int              since_m;

   always #5 clk = ~clk;

   reg_file_sb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
      .a3(a3), .wd3(wd3), .we3(we3), .sb_set(sb_set), .sb_addr(sb_addr),
      .busy1(busy1), .busy2(busy2), .init_done(init_done)
   );

   function automatic logic [XLEN-1:0] exp_rd(logic [ADDR_W-1:0] a);
      if (!ready_m || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (we3 && a3 == a) return wd3;
`endif
      return mem_m[a];
   endfunction

   function automatic logic exp_busy(logic [ADDR_W-1:0] a);
      if (!ready_m || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (we3 && a3 == a) return 1'b0;
`endif
      return pend_m[a];
   endfunction

   task automatic chk(string tag, logic [XLEN-1:0] obs, logic [XLEN-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      #1;
      chk({tag, ".rd1"}, rd1, exp_rd(a1));
      chk({tag, ".rd2"}, rd2, exp_rd(a2));
      chk({tag, ".busy1"}, {31'b0, busy1}, {31'b0, exp_busy(a1)});
      chk({tag, ".busy2"}, {31'b0, busy2}, {31'b0, exp_busy(a2)});
      chk({tag, ".init_done"}, {31'b0, init_done}, {31'b0, ready_m});
   endtask

   task automatic model_reset();
      ready_m = 1'b0;
      since_m = 0;
      foreach (pend_m[i]) pend_m[i] = 1'b0;
   endtask

   // Advance one clock; the model applies the inputs that were stable at the edge.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (!ready_m) begin
         since_m++;
         if (since_m == NREGS) begin
            ready_m = 1'b1;
            foreach (mem_m[i]) mem_m[i] = '0;
         end
      end else begin
         if (we3 && a3 != 0) mem_m[a3] = wd3;
         if (we3) pend_m[a3] = 1'b0;
         if (sb_set) pend_m[sb_addr] = 1'b1;
         pend_m[0] = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      we3    = 1'b0;
      sb_set = 1'b0;
   endtask

   function automatic logic [ADDR_W-1:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom);
      return ADDR_W'($urandom_range(0, 7));
   endfunction

   initial begin
      foreach (mem_m[i]) mem_m[i] = '0;
      model_reset();

      @(negedge clk);
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // First clear attempt, disturbed by writes/issues that must be ignored.
      for (int k = 0; k < 10; k++) begin
         we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF; a1 = 5'd5; a2 = rnd_addr();
         sb_set = 1'b1; sb_addr = 5'd5;
         check_all("clear1");
         tick();
      end

      rst = 1'b1;
      model_reset();
      check_all("midrst");
      tick();
      rst = 1'b0;

      for (int k = 0; k < NREGS; k++) begin
         we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF; a1 = 5'd5; a2 = rnd_addr();
         sb_set = 1'b1; sb_addr = 5'd5;
         check_all("clear2");
         chk("clear2.low", {31'b0, init_done}, 32'd0);
         tick();
      end
      idle();
      a1 = 5'd5;
      check_all("ready");
      chk("init_rise", {31'b0, init_done}, 32'd1);
      chk("x5_cleared", rd1, 32'h0);
      chk("x5_not_busy", {31'b0, busy1}, 32'd0);

      for (int i = 0; i < NREGS; i++) begin
         a1 = ADDR_W'(i); a2 = ADDR_W'(NREGS - 1 - i);
         check_all("zero_scan");
         tick();
      end

      we3 = 1'b1; a3 = 5'd7; wd3 = 32'h12345678; a1 = 5'd7;
      check_all("x7_wr");
      tick(); idle();
      check_all("x7_rd");
      chk("x7_val", rd1, 32'h12345678);

      we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF; a2 = 5'd0;
      check_all("x0_wr");
      tick(); idle();
      check_all("x0_rd");
      chk("x0_val", rd2, 32'h0);

      sb_set = 1'b1; sb_addr = 5'd0; a1 = 5'd0;
      check_all("x0_sb");
      tick(); idle();
      check_all("x0_sb_after");
      chk("x0_busy", {31'b0, busy1}, 32'd0);

      we3 = 1'b1; a3 = 5'd9; wd3 = 32'hA5A5A5A5; a1 = 5'd9;
      check_all("x9_same");
`ifdef REGFILE_BYPASS_EN
      chk("x9_same_val", rd1, 32'hA5A5A5A5);
`else
      chk("x9_same_val", rd1, 32'h0);
`endif
      tick(); idle();
      check_all("x9_next");
      chk("x9_next_val", rd1, 32'hA5A5A5A5);

      sb_set = 1'b1; sb_addr = 5'd12; a1 = 5'd12;
      tick(); idle();
      check_all("x12_set");
      chk("x12_busy", {31'b0, busy1}, 32'd1);
      we3 = 1'b1; a3 = 5'd12; wd3 = 32'h0BADF00D; sb_set = 1'b1; sb_addr = 5'd12;
      check_all("x12_both");
      tick(); idle();
      check_all("x12_both_after");
      chk("x12_setwins", {31'b0, busy1}, 32'd1);
      we3 = 1'b1; a3 = 5'd12; wd3 = 32'h600DF00D;
      tick(); idle();
      check_all("x12_clr");
      chk("x12_cleared", {31'b0, busy1}, 32'd0);

      sb_set = 1'b1; sb_addr = 5'd4;
      tick(); idle();
      sb_set = 1'b1; sb_addr = 5'd3; we3 = 1'b1; a3 = 5'd4; wd3 = 32'h44444444;
      a1 = 5'd3; a2 = 5'd4;
      check_all("x3x4_same");
      tick(); idle();
      check_all("x3x4_after");
      chk("x3_busy", {31'b0, busy1}, 32'd1);
      chk("x4_busy", {31'b0, busy2}, 32'd0);

      for (int n = 0; n < 400; n++) begin
         a1 = rnd_addr(); a2 = rnd_addr(); a3 = rnd_addr(); sb_addr = rnd_addr();
         wd3 = $urandom; we3 = 1'($urandom); sb_set = 1'($urandom);
         if (n == 200) begin
            rst = 1'b1;
            model_reset();
         end else if (n == 202) begin
            rst = 1'b0;
         end
         check_all("rand");
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
